// File: rtl/exp_pkg.sv
// Shared definitions for the expand-layer bias ("bash") loader and its neighbours.
package exp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StArm,
    StFetch,
    StDrain,
    StWaitRdy
  } exp_bash_ld_state_t;

  localparam int unsigned EXP_BASH_WORD_BYTES = 8;
  localparam int unsigned EXP_BASH_FIFO_DEPTH = 128;

endpackage

// File: rtl/exp_bash_loader.sv
// Per-layer sequencer: clears the bash FIFO, arms the bash controller, then streams the
// bias words from external memory into the FIFO as flow-controlled read bursts.
module exp_bash_loader
  import exp_pkg::*;
#(
  parameter int unsigned BURST_MAX  = 16,
  parameter int unsigned FIFO_LIMIT = 120
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        layer_start_i,
  input  logic [31:0] bash_base_addr_i,
  input  logic [5:0]  no_of_exp_kernals_i,
  output logic        rd_cmd_valid_o,
  input  logic        rd_cmd_ready_i,
  output logic [31:0] rd_addr_o,
  output logic [6:0]  rd_len_o,
  input  logic [63:0] rd_data_i,
  input  logic        rd_data_valid_i,
  output logic        fifo_exp_bash_clr_o,
  output logic [63:0] fifo_exp_bash_wr_data_o,
  output logic        fifo_exp_bash_wr_en_o,
  input  logic [6:0]  fifo_exp_bash_data_count_i,
  output logic        bash_start_o,
  output logic [5:0]  no_of_exp_kernals_o,
  input  logic        bash_ram_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  exp_bash_ld_state_t state_q;
  logic [31:0] base_q;
  logic [6:0]  n_q;
  logic [6:0]  req_q;
  logic [6:0]  rcv_q;

  logic [6:0]  remain;
  logic [6:0]  len_c;
  logic [6:0]  in_flight;
  logic [8:0]  need;
  logic        fits;
  logic [31:0] addr_c;
  logic        rx_ok;

  always_comb begin
    remain    = n_q - req_q;
    len_c     = (remain > 7'(BURST_MAX)) ? 7'(BURST_MAX) : remain;
    in_flight = req_q - rcv_q;
    // Widened so the occupancy sum cannot wrap before the limit compare.
    need      = {2'b00, fifo_exp_bash_data_count_i} + {2'b00, in_flight} + {2'b00, len_c};
    fits      = (need <= 9'(FIFO_LIMIT)) && (req_q < n_q);
    addr_c    = base_q + 32'(req_q) * EXP_BASH_WORD_BYTES;
    rx_ok     = ((state_q == StFetch) || (state_q == StDrain)) && (rcv_q < n_q);
  end

  assign busy_o = (state_q != StIdle);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q                 <= StIdle;
      base_q                  <= '0;
      n_q                     <= '0;
      req_q                   <= '0;
      rcv_q                   <= '0;
      rd_cmd_valid_o          <= 1'b0;
      rd_addr_o               <= '0;
      rd_len_o                <= '0;
      fifo_exp_bash_clr_o     <= 1'b0;
      fifo_exp_bash_wr_data_o <= '0;
      fifo_exp_bash_wr_en_o   <= 1'b0;
      bash_start_o            <= 1'b0;
      no_of_exp_kernals_o     <= '0;
      done_o                  <= 1'b0;
      err_o                   <= 1'b0;
    end else begin
      fifo_exp_bash_clr_o   <= 1'b0;
      bash_start_o          <= 1'b0;
      fifo_exp_bash_wr_en_o <= 1'b0;
      done_o                <= 1'b0;

      if (rd_data_valid_i) begin
        if (rx_ok) begin
          fifo_exp_bash_wr_en_o   <= 1'b1;
          fifo_exp_bash_wr_data_o <= rd_data_i;
          rcv_q                   <= rcv_q + 7'd1;
        end else begin
          err_o <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (layer_start_i) begin
            base_q              <= bash_base_addr_i;
            no_of_exp_kernals_o <= no_of_exp_kernals_i;
            n_q                 <= {1'b0, no_of_exp_kernals_i} + 7'd1;
            req_q               <= '0;
            rcv_q               <= '0;
            err_o               <= 1'b0;
            fifo_exp_bash_clr_o <= 1'b1;
            state_q             <= StClear;
          end
        end
        StClear: begin
          bash_start_o <= 1'b1;
          state_q      <= StArm;
        end
        StArm, StFetch: begin
          if (state_q == StArm) state_q <= StFetch;
          if (rd_cmd_valid_o) begin
            if (rd_cmd_ready_i) begin
              rd_cmd_valid_o <= 1'b0;
              req_q          <= req_q + rd_len_o;
              if (req_q + rd_len_o == n_q) state_q <= StDrain;
            end
          end else if (fits) begin
            rd_cmd_valid_o <= 1'b1;
            rd_addr_o      <= addr_c;
            rd_len_o       <= len_c;
          end
        end
        StDrain: begin
          if (rcv_q == n_q) state_q <= StWaitRdy;
        end
        StWaitRdy: begin
          if (bash_ram_ready_i) begin
            done_o  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_bash_loader.sv
// Directed bench for exp_bash_loader with a delayed-return memory responder.
module tb_exp_bash_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        layer_start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [5:0]  kern_in = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [31:0] cmd_addr;
  logic [6:0]  cmd_len;
  logic [63:0] resp_data = '0, man_data = '0;
  logic        resp_v = 1'b0, man_v = 1'b0;
  logic        fifo_clr, fifo_wr_en;
  logic [63:0] fifo_wr_data;
  logic [6:0]  data_count = '0;
  logic        bash_start;
  logic [5:0]  kern_out;
  logic        ram_ready = 1'b0;
  logic        busy, done, err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] cmd_log_addr[$];
  logic [6:0]  cmd_log_len[$];
  logic [63:0] wr_log[$];
  logic [31:0] pend_addr[$];
  int          pend_t[$];

  exp_bash_loader dut (
    .clk_i                      (clk),
    .rst_n_i                    (rst_n),
    .layer_start_i              (layer_start),
    .bash_base_addr_i           (base_addr),
    .no_of_exp_kernals_i        (kern_in),
    .rd_cmd_valid_o             (cmd_valid),
    .rd_cmd_ready_i             (cmd_ready),
    .rd_addr_o                  (cmd_addr),
    .rd_len_o                   (cmd_len),
    .rd_data_i                  (man_v ? man_data : resp_data),
    .rd_data_valid_i            (resp_v | man_v),
    .fifo_exp_bash_clr_o        (fifo_clr),
    .fifo_exp_bash_wr_data_o    (fifo_wr_data),
    .fifo_exp_bash_wr_en_o      (fifo_wr_en),
    .fifo_exp_bash_data_count_i (data_count),
    .bash_start_o               (bash_start),
    .no_of_exp_kernals_o        (kern_out),
    .bash_ram_ready_i           (ram_ready),
    .busy_o                     (busy),
    .done_o                     (done),
    .err_o                      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'hB1A5_0000, a};
  endfunction

  // Log accepted commands and FIFO writes; queue each requested word for return 3 cycles later.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && cmd_valid && cmd_ready) begin
      cmd_log_addr.push_back(cmd_addr);
      cmd_log_len.push_back(cmd_len);
      for (int i = 0; i < int'(cmd_len); i++) begin
        pend_addr.push_back(cmd_addr + 32'(i * 8));
        pend_t.push_back(cyc + 3);
      end
    end
    if (rst_n && fifo_wr_en) wr_log.push_back(fifo_wr_data);
  end

  always @(negedge clk) begin
    resp_v = 1'b0;
    if (!rst_n) begin
      pend_addr.delete();
      pend_t.delete();
    end else if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
      resp_v    = 1'b1;
      resp_data = pat(pend_addr.pop_front());
      void'(pend_t.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    cmd_log_addr.delete();
    cmd_log_len.delete();
    wr_log.delete();
  endtask

  // Ends at the negedge of cycle T+1 (start sampled at the posedge opening T+1).
  task automatic start(input logic [31:0] a, input logic [5:0] k);
    @(negedge clk);
    base_addr   = a;
    kern_in     = k;
    layer_start = 1'b1;
    @(negedge clk);
    layer_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    logic got;
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, got, 1'b1);
  endtask

  task automatic wait_valid(input string tag, input int bound);
    logic got;
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, got, 1'b1);
  endtask

  initial begin
    int stable;
    logic [31:0] a0;
    logic [6:0]  l0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_addr", cmd_addr, 32'h0);
    chk("rst_len", cmd_len, 7'h0);
    chk("rst_kern", kern_out, 6'h0);
    chk("rst_busy_done_err", {busy, done, err, fifo_clr, bash_start, fifo_wr_en}, 6'b0);
    rst_n = 1'b1;

    // N=5, base 0x1000: pulse timing, single command, ordered writes
    clear_logs();
    start(32'h1000, 6'd4);
    chk("t1_clr_T1", {fifo_clr, bash_start, busy}, 3'b101);
    @(negedge clk);
    chk("t1_start_T2", {fifo_clr, bash_start, cmd_valid}, 3'b010);
    @(negedge clk);
    chk("t1_valid_T3", cmd_valid, 1'b1);
    chk("t1_addr", cmd_addr, 32'h1000);
    chk("t1_len", cmd_len, 7'd5);
    repeat (15) @(negedge clk);
    chk("t1_cmds", cmd_log_addr.size(), 1);
    chk("t1_writes", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++)
      chk($sformatf("t1_wr%0d", i), wr_log[i], pat(32'h1000 + 32'(i * 8)));
    chk("t1_busy_waiting", {busy, done}, 2'b10);
    chk("t1_kern", kern_out, 6'd4);
    ram_ready = 1'b1;
    wait_done("t1_done", 10);
    chk("t1_busy_at_done", busy, 1'b0);
    ram_ready = 1'b0;

    // N=64: four full bursts
    clear_logs();
    ram_ready = 1'b1;
    start(32'h1000, 6'd63);
    wait_done("t2_done", 300);
    chk("t2_cmds", cmd_log_addr.size(), 4);
    for (int i = 0; i < 4 && i < cmd_log_addr.size(); i++) begin
      chk($sformatf("t2_addr%0d", i), cmd_log_addr[i], 32'h1000 + 32'(i * 128));
      chk($sformatf("t2_len%0d", i), cmd_log_len[i], 7'd16);
    end
    chk("t2_writes", wr_log.size(), 64);
    if (wr_log.size() == 64) chk("t2_last_wr", wr_log[63], pat(32'h11F8));

    // N=40 with FIFO nearly full: 110+0+16 > 120 stalls, 104+0+16 = 120 issues
    clear_logs();
    data_count = 7'd110;
    start(32'h2000, 6'd39);
    repeat (12) @(negedge clk);
    chk("t3_stalled_valid", cmd_valid, 1'b0);
    chk("t3_stalled_cmds", cmd_log_addr.size(), 0);
    data_count = 7'd104;
    wait_done("t3_done", 300);
    data_count = 7'd0;
    chk("t3_cmds", cmd_log_addr.size(), 3);
    if (cmd_log_addr.size() == 3) begin
      chk("t3_addr2", cmd_log_addr[2], 32'h2100);
      chk("t3_lens", {cmd_log_len[0], cmd_log_len[1], cmd_log_len[2]}, {7'd16, 7'd16, 7'd8});
    end
    chk("t3_writes", wr_log.size(), 40);
    ram_ready = 1'b0;

    // Command held off for 7 cycles, then a 6th unrequested strobe
    clear_logs();
    cmd_ready = 1'b0;
    start(32'h3000, 6'd4);
    wait_valid("t4_valid", 10);
    a0 = cmd_addr;
    l0 = cmd_len;
    stable = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_addr === a0 && cmd_len === l0) stable++;
    end
    chk("t4_stable_cycles", stable, 7);
    chk("t4_held_addr_len", {a0, l0}, {32'h3000, 7'd5});
    cmd_ready = 1'b1;
    repeat (15) @(negedge clk);
    chk("t4_accepts", cmd_log_addr.size(), 1);
    chk("t4_writes", wr_log.size(), 5);
    chk("t4_err_before", err, 1'b0);
    man_v    = 1'b1;
    man_data = 64'hDEAD_BEEF_0000_0006;
    @(negedge clk);
    man_v = 1'b0;
    chk("t5_err_set", {err, fifo_wr_en}, 2'b10);
    @(negedge clk);
    chk("t5_dropped", wr_log.size(), 5);
    ram_ready = 1'b1;
    wait_done("t5_done", 10);
    chk("t5_err_sticky", err, 1'b1);
    ram_ready = 1'b0;

    // Next start clears err; a start during FETCH is ignored; async reset mid-FETCH
    clear_logs();
    cmd_ready = 1'b0;
    start(32'h4000, 6'd2);
    chk("t6_err_cleared", err, 1'b0);
    wait_valid("t6_valid", 10);
    start(32'h9000, 6'd9);
    chk("t6_restart_ignored", {fifo_clr, kern_out}, {1'b0, 6'd2});
    chk("t6_addr_kept", cmd_addr, 32'h4000);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid_busy", {cmd_valid, busy, done, err}, 4'b0);
    chk("t6_rst_addr_len_kern", {cmd_addr, cmd_len, kern_out}, 45'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    cmd_ready = 1'b1;
    ram_ready = 1'b1;
    clear_logs();
    start(32'h5000, 6'd4);
    wait_done("t6_restart_done", 60);
    chk("t6_restart_writes", wr_log.size(), 5);
    if (wr_log.size() == 5) chk("t6_restart_last", wr_log[4], pat(32'h5020));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
